// File: rtl/pc_sequencer.sv
// Program-counter unit: registered fetch address, opcode-selected next address,
// and a return-address stack with sticky overflow/underflow flags.
module pc_sequencer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int START_ADDR  = 'h400,
  parameter int STEP        = 1,
  parameter int STACK_DEPTH = 8,
  parameter int CNT_WIDTH   = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  clearN,
  input  logic                  pcWrite,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] target,
  input  logic [ADDR_WIDTH-1:0] offset,
  input  logic                  errClear,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [CNT_WIDTH-1:0]  stackCount,
  output logic                  stackFull,
  output logic                  stackEmpty,
  output logic                  overflowErr,
  output logic                  underflowErr
);

  typedef enum logic [2:0] {
    OP_HOLD    = 3'd0,
    OP_INC     = 3'd1,
    OP_BRANCH  = 3'd2,
    OP_JUMP    = 3'd3,
    OP_CALL    = 3'd4,
    OP_RET     = 3'd5,
    OP_RESTART = 3'd6,
    OP_RSVD    = 3'd7
  } op_e;

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP_A  = ADDR_WIDTH'(STEP);
  localparam logic [CNT_WIDTH-1:0]  DEPTH_C = CNT_WIDTH'(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic                  push_en;
  logic [ADDR_WIDTH-1:0] push_val;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      top_idx;
  logic                  full;
  logic                  empty;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign wr_idx  = IDX_W'(cnt_q);
  assign top_idx = IDX_W'(cnt_q - 1'b1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q & ~errClear;
    unf_d    = unf_q & ~errClear;
    push_en  = 1'b0;
    push_val = pc_q + STEP_A;

    if (pcWrite) begin
      case (op_e'(op))
        OP_INC:    pc_d = pc_q + STEP_A;
        OP_BRANCH: pc_d = pc_q + offset;
        OP_JUMP:   pc_d = target;
        OP_CALL: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            push_en = 1'b1;
            pc_d    = target;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        OP_RET: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            pc_d  = stack_q[top_idx];
            cnt_d = cnt_q - 1'b1;
          end
        end
        OP_RESTART: begin
          pc_d  = START_A;
          cnt_d = '0;
        end
        default: ;  // HOLD and reserved leave everything as is
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge clearN) begin
    if (!clearN) begin
      pc_q  <= START_A;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // NOTE: stack storage is deliberately not reset; entries above stackCount are never read.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[wr_idx] <= push_val;
  end

  assign pc           = pc_q;
  assign stackCount   = cnt_q;
  assign stackFull    = full;
  assign stackEmpty   = empty;
  assign overflowErr  = ovf_q;
  assign underflowErr = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: queue-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        clearN;
  logic        pcWrite;
  logic [2:0]  op;
  logic [15:0] target;
  logic [15:0] offset;
  logic        errClear;
  logic [15:0] pc;
  logic [3:0]  stackCount;
  logic        stackFull;
  logic        stackEmpty;
  logic        overflowErr;
  logic        underflowErr;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  bit          m_ovf;
  bit          m_unf;

  pc_sequencer dut (
    .clk(clk), .clearN(clearN), .pcWrite(pcWrite), .op(op),
    .target(target), .offset(offset), .errClear(errClear),
    .pc(pc), .stackCount(stackCount), .stackFull(stackFull),
    .stackEmpty(stackEmpty), .overflowErr(overflowErr),
    .underflowErr(underflowErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0400;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  // Applies the opcode rules to the model using the inputs present at the edge.
  task automatic model_step();
    bit ov = 0;
    bit un = 0;
    if (pcWrite) begin
      case (op)
        3'd1: m_pc = m_pc + 16'd1;
        3'd2: m_pc = m_pc + offset;
        3'd3: m_pc = target;
        3'd4: if (m_stk.size() == 8) ov = 1;
              else begin m_stk.push_back(m_pc + 16'd1); m_pc = target; end
        3'd5: if (m_stk.size() == 0) un = 1;
              else m_pc = m_stk.pop_back();
        3'd6: begin m_pc = 16'h0400; m_stk.delete(); end
        default: ;
      endcase
    end
    m_ovf = ov | (m_ovf & !errClear);
    m_unf = un | (m_unf & !errClear);
  endtask

  task automatic do_op(input logic pw, input logic [2:0] o, input logic [15:0] tgt,
                       input logic [15:0] off, input logic ec);
    pcWrite = pw; op = o; target = tgt; offset = off; errClear = ec;
    @(posedge clk);
    model_step();
    #1;
    pcWrite = 0; errClear = 0;
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    check("pc", pc, m_pc);
    check("stackCount", stackCount, m_stk.size());
    check("stackFull", stackFull, m_stk.size() == 8);
    check("stackEmpty", stackEmpty, m_stk.size() == 0);
    check("overflowErr", overflowErr, m_ovf);
    check("underflowErr", underflowErr, m_unf);
  end

  initial begin
    clearN = 0; pcWrite = 0; op = 0; target = 0; offset = 0; errClear = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 clearN = 1;
    check("reset_pc", pc, 16'h0400);
    check("reset_empty", stackEmpty, 1'b1);

    // increment and wrap
    repeat (3) do_op(1, 3'd1, 0, 0, 0);
    check("inc3_pc", pc, 16'h0403);
    do_op(1, 3'd3, 16'hFFFF, 0, 0);
    do_op(1, 3'd1, 0, 0, 0);
    check("inc_wrap_pc", pc, 16'h0000);

    // signed branch
    do_op(1, 3'd3, 16'h0410, 0, 0);
    do_op(1, 3'd2, 0, 16'hFFF0, 0);
    check("branch_back", pc, 16'h0400);
    do_op(1, 3'd2, 0, 16'h0020, 0);
    check("branch_fwd", pc, 16'h0420);

    // nested call / return
    do_op(1, 3'd6, 0, 0, 0);
    check("restart_pc", pc, 16'h0400);
    do_op(1, 3'd4, 16'h0500, 0, 0);
    do_op(1, 3'd4, 16'h0600, 0, 0);
    check("call2_count", stackCount, 4'd2);
    check("call2_pc", pc, 16'h0600);
    do_op(1, 3'd5, 0, 0, 0);
    check("ret1_pc", pc, 16'h0501);
    do_op(1, 3'd5, 0, 0, 0);
    check("ret2_pc", pc, 16'h0401);
    check("ret2_empty", stackEmpty, 1'b1);

    // overflow
    for (int i = 0; i < 8; i++) do_op(1, 3'd4, 16'h1000 + 16'(i), 0, 0);
    check("full_flag", stackFull, 1'b1);
    do_op(1, 3'd4, 16'h2000, 0, 0);
    check("ovf_pc_hold", pc, 16'h1007);
    check("ovf_flag", overflowErr, 1'b1);
    check("ovf_count", stackCount, 4'd8);
    do_op(0, 3'd0, 0, 0, 1);
    check("ovf_cleared", overflowErr, 1'b0);
    do_op(1, 3'd5, 0, 0, 0);
    check("ret_after_full", pc, 16'h1007);

    // underflow, gating, set-wins
    do_op(1, 3'd6, 0, 0, 0);
    do_op(1, 3'd5, 0, 0, 0);
    check("unf_flag", underflowErr, 1'b1);
    check("unf_pc_hold", pc, 16'h0400);
    do_op(0, 3'd3, 16'h1234, 0, 0);
    check("gated_jump", pc, 16'h0400);
    do_op(1, 3'd5, 0, 0, 1);
    check("set_wins", underflowErr, 1'b1);
    do_op(1, 3'd6, 0, 0, 0);
    check("restart_keeps_flag", underflowErr, 1'b1);
    do_op(0, 3'd0, 0, 0, 1);
    check("unf_cleared", underflowErr, 1'b0);

    // asynchronous reset between edges
    for (int i = 0; i < 3; i++) do_op(1, 3'd4, 16'h0700 + 16'(i), 0, 0);
    do_op(1, 3'd3, 16'h0777, 0, 0);
    check("pre_rst_count", stackCount, 4'd3);
    check("pre_rst_pc", pc, 16'h0777);
    #2 clearN = 0;
    model_reset();
    #1;
    check("async_rst_pc", pc, 16'h0400);
    check("async_rst_count", stackCount, 4'd0);
    #2 clearN = 1;

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      if (o == 3'd6 && $urandom_range(0, 3) != 0) o = 3'd4;  // keep restarts rare
      do_op(($urandom_range(0, 7) != 0), o, 16'($urandom), 16'($urandom),
            ($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
